// File: rtl/mem_reader_multi_if.sv
// Bundle between the conv-engine memory reader (slave) and its controller/datapath (master).
interface mem_reader_multi_if #(
    parameter int DATA_W     = 8,
    parameter int WORD_BYTES = 4,
    parameter int MEM_DEPTH  = 128,
    parameter int IMG_SIZE   = 16,
    parameter int NUM_FILT   = 4,
    parameter int FILT_LEN   = 16
);
    localparam int ADDR_W = $clog2(MEM_DEPTH);

    logic                                          start;
    logic                                          load_en;
    logic [ADDR_W-1:0]                             load_addr;
    logic [DATA_W*WORD_BYTES-1:0]                  load_data;
    logic [ADDR_W-1:0]                             filt_base;
    logic [ADDR_W-1:0]                             img_base;
    logic [7:0]                                    line_stride;
    logic                                          busy;
    logic                                          done;
    logic                                          err;
    logic [IMG_SIZE*IMG_SIZE-1:0][DATA_W-1:0]      img_data;
    logic [NUM_FILT-1:0][FILT_LEN-1:0][DATA_W-1:0] filters;

    modport master (
        output start, load_en, load_addr, load_data, filt_base, img_base, line_stride,
        input  busy, done, err, img_data, filters
    );

    modport slave (
        input  start, load_en, load_addr, load_data, filt_base, img_base, line_stride,
        output busy, done, err, img_data, filters
    );
endinterface

// File: rtl/mem_reader_multi.sv
// Word-addressed input RAM plus a read sequencer that unpacks NUM_FILT filters and an
// IMG_SIZE x IMG_SIZE strided image window into registered arrays for the conv datapath.
module mem_reader_multi #(
    parameter int DATA_W     = 8,
    parameter int WORD_BYTES = 4,
    parameter int MEM_DEPTH  = 128,
    parameter int IMG_SIZE   = 16,
    parameter int NUM_FILT   = 4,
    parameter int FILT_LEN   = 16
) (
    input logic               clk,
    input logic               rst,
    mem_reader_multi_if.slave bus
);
    localparam int ADDR_W  = $clog2(MEM_DEPTH);
    localparam int AW2     = ADDR_W + 9;
    localparam int WORD_W  = DATA_W * WORD_BYTES;
    localparam int NE_F    = NUM_FILT * FILT_LEN;
    localparam int NE_I    = IMG_SIZE * IMG_SIZE;
    localparam int FW      = NE_F / WORD_BYTES;
    localparam int IW      = NE_I / WORD_BYTES;
    localparam int RW      = IMG_SIZE / WORD_BYTES;
    localparam int MAXW    = (IW > FW) ? IW : FW;
    localparam int CNT_W   = $clog2(MAXW + 1);
    localparam int FIDX_W  = $clog2(NE_F);
    localparam int IIDX_W  = $clog2(NE_I);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_RD_FILT, S_RD_IMG, S_DRAIN, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  wcol_q, wcol_d;
    logic [AW2-1:0]    row_off_q, row_off_d;
    logic [ADDR_W-1:0] fbase_q, fbase_d;
    logic [ADDR_W-1:0] ibase_q, ibase_d;
    logic [7:0]        stride_q, stride_d;
    logic              err_q, err_d;

    logic              rd_en;
    logic              oob;
    logic [AW2-1:0]    rd_addr;
    logic              wr_en;

    logic [WORD_W-1:0] mem [MEM_DEPTH];

    logic              vld_p1;
    logic              img_sel_p1;
    logic              oob_p1;
    logic [CNT_W-1:0]  idx_p1;
    logic [WORD_W-1:0] rdata_p1;

    logic [NE_I-1:0][DATA_W-1:0] img_q, img_d;
    logic [NE_F-1:0][DATA_W-1:0] filt_q, filt_d;
    logic [DATA_W-1:0]           elem;

    // Sequencer: one word address per cycle in the read states, oob words never touch the RAM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wcol_d    = wcol_q;
        row_off_d = row_off_q;
        fbase_d   = fbase_q;
        ibase_d   = ibase_q;
        stride_d  = stride_q;
        err_d     = err_q;
        rd_en     = 1'b0;
        rd_addr   = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_ARM;
                    cnt_d     = '0;
                    wcol_d    = '0;
                    row_off_d = '0;
                    fbase_d   = bus.filt_base;
                    ibase_d   = bus.img_base;
                    stride_d  = bus.line_stride;
                    err_d     = 1'b0;
                end
            end
            S_ARM: state_d = S_RD_FILT;
            S_RD_FILT: begin
                rd_en   = 1'b1;
                rd_addr = AW2'(fbase_q) + AW2'(cnt_q);
                if (cnt_q == CNT_W'(FW - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RD_IMG;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD_IMG: begin
                rd_en   = 1'b1;
                rd_addr = AW2'(ibase_q) + row_off_q + AW2'(wcol_q);
                // Row offset accumulates the stride instead of multiplying row by stride
                if (wcol_q == CNT_W'(RW - 1)) begin
                    wcol_d    = '0;
                    row_off_d = row_off_q + AW2'(stride_q);
                end else begin
                    wcol_d = wcol_q + 1'b1;
                end
                if (cnt_q == CNT_W'(IW - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        oob = rd_en && (rd_addr >= AW2'(MEM_DEPTH));
        if (oob) begin
            err_d = 1'b1;
        end
    end

    assign wr_en = bus.load_en && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wcol_q    <= '0;
            row_off_q <= '0;
            fbase_q   <= '0;
            ibase_q   <= '0;
            stride_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wcol_q    <= wcol_d;
            row_off_q <= row_off_d;
            fbase_q   <= fbase_d;
            ibase_q   <= ibase_d;
            stride_q  <= stride_d;
            err_q     <= err_d;
        end
    end

    // Stage p0 -> p1: RAM read and the destination tag travelling with it
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bus.load_addr] <= bus.load_data;
        end
        if (rd_en && !oob) begin
            rdata_p1 <= mem[rd_addr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
            img_sel_p1 <= 1'b0;
            oob_p1     <= 1'b0;
            idx_p1     <= '0;
        end else begin
            vld_p1     <= rd_en;
            img_sel_p1 <= (state_q == S_RD_IMG);
            oob_p1     <= oob;
            idx_p1     <= cnt_q;
        end
    end

    // Stage p1 -> outputs: word j lands at flat element j*WORD_BYTES for both arrays,
    // since an image row is exactly RW words wide
    always_comb begin
        img_d  = img_q;
        filt_d = filt_q;
        elem   = '0;
        if (vld_p1) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                elem = oob_p1 ? '0 : rdata_p1[b*DATA_W +: DATA_W];
                if (img_sel_p1) begin
                    img_d[IIDX_W'(int'(idx_p1) * WORD_BYTES + b)] = elem;
                end else begin
                    filt_d[FIDX_W'(int'(idx_p1) * WORD_BYTES + b)] = elem;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            img_q  <= '0;
            filt_q <= '0;
        end else begin
            img_q  <= img_d;
            filt_q <= filt_d;
        end
    end

    assign bus.busy     = (state_q == S_RD_FILT) || (state_q == S_RD_IMG) || (state_q == S_DRAIN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.err      = err_q;
    assign bus.img_data = img_q;
    assign bus.filters  = filt_q;
endmodule

// File: tb/tb_mem_reader_multi.sv
// Directed bench for mem_reader_multi: load, strided reads, range errors, busy-time inputs, abort.
module tb_mem_reader_multi;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_reader_multi_if bus ();

    mem_reader_multi dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_elem(input int a, input int b);
        if (a >= 128) return 8'd0;
        return 8'((4 * a + b) & 255);
    endfunction

    function automatic logic [7:0] exp_img(input int base, input int stride, input int idx);
        int r;
        int c;
        r = idx / 16;
        c = idx % 16;
        return exp_elem(base + r * stride + c / 4, c % 4);
    endfunction

    task automatic load_all();
        for (int a = 0; a < 128; a++) begin
            @(negedge clk);
            bus.load_en   = 1'b1;
            bus.load_addr = 7'(a);
            bus.load_data = {8'(4 * a + 3), 8'(4 * a + 2), 8'(4 * a + 1), 8'(4 * a)};
        end
        @(negedge clk);
        bus.load_en = 1'b0;
    endtask

    // Drives one pass; cycle numbers are counted in edges from the edge that samples start
    task automatic run_pass(input bit ld, input bit inj, output int done_edge, output int done_cnt,
                            output int busy_cnt, output int first_busy, output int post_busy);
        done_edge  = -1;
        done_cnt   = 0;
        busy_cnt   = 0;
        first_busy = -1;
        post_busy  = 0;
        @(negedge clk);
        bus.start = 1'b1;
        if (ld) bus.load_en = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                bus.start   = 1'b0;
                bus.load_en = 1'b0;
            end
            if (inj && cyc == 10) begin
                bus.start     = 1'b1;
                bus.load_en   = 1'b1;
                bus.load_addr = 7'd5;
                bus.load_data = 32'hDEADBEEF;
                bus.filt_base = 7'd50;
            end
            if (inj && cyc == 11) begin
                bus.start     = 1'b0;
                bus.load_en   = 1'b0;
                bus.filt_base = 7'd0;
            end
            if (done_edge >= 0 && cyc == done_edge + 1) bus.start = 1'b0;
            if (bus.busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = cyc;
                if (done_edge >= 0) post_busy++;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = cyc;
                    if (inj) bus.start = 1'b1;
                end
            end
            if (done_edge >= 0 && cyc == done_edge + 5) break;
        end
    endtask

    task automatic test_reset();
        rst             = 1'b0;
        bus.start       = 1'b0;
        bus.load_en     = 1'b0;
        bus.load_addr   = '0;
        bus.load_data   = '0;
        bus.filt_base   = '0;
        bus.img_base    = '0;
        bus.line_stride = '0;
        #12;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
        checks++; if (bus.img_data !== '0) begin errors++; $display("FAIL reset_img got nonzero exp 0"); end
        checks++; if (bus.filters !== '0) begin errors++; $display("FAIL reset_filt got nonzero exp 0"); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_basic();
        int de, dc, bc, fb, pb;
        load_all();
        bus.filt_base = 7'd0; bus.img_base = 7'd16; bus.line_stride = 8'd4;
        run_pass(1'b0, 1'b0, de, dc, bc, fb, pb);
        checks++; if (de != 82) begin errors++; $display("FAIL t1_done_edge got %0d exp 82", de); end
        checks++; if (dc != 1) begin errors++; $display("FAIL t1_done_cnt got %0d exp 1", dc); end
        checks++; if (fb != 1) begin errors++; $display("FAIL t1_first_busy got %0d exp 1", fb); end
        checks++; if (bc != 81) begin errors++; $display("FAIL t1_busy_cycles got %0d exp 81", bc); end
        checks++; if (bus.filters[1][0] !== 8'd16) begin errors++; $display("FAIL t1_filt10 got %0d exp 16", bus.filters[1][0]); end
        checks++; if (bus.filters[3][15] !== 8'd63) begin errors++; $display("FAIL t1_filt315 got %0d exp 63", bus.filters[3][15]); end
        checks++; if (bus.img_data[16] !== 8'd80) begin errors++; $display("FAIL t1_img16 got %0d exp 80", bus.img_data[16]); end
        checks++; if (bus.img_data[255] !== 8'd63) begin errors++; $display("FAIL t1_img255 got %0d exp 63", bus.img_data[255]); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL t1_err got %b exp 0", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after got %b exp 0", bus.busy); end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (bus.filters[i/16][i%16] !== exp_elem(i / 4, i % 4)) begin
                errors++; $display("FAIL t1_filt[%0d] got %0d exp %0d", i, bus.filters[i/16][i%16], exp_elem(i / 4, i % 4));
            end
        end
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (bus.img_data[i] !== exp_img(16, 4, i)) begin
                errors++; $display("FAIL t1_img[%0d] got %0d exp %0d", i, bus.img_data[i], exp_img(16, 4, i));
            end
        end
    endtask

    task automatic test_stride();
        int de, dc, bc, fb, pb;
        bus.filt_base = 7'd0; bus.img_base = 7'd0; bus.line_stride = 8'd8;
        run_pass(1'b0, 1'b0, de, dc, bc, fb, pb);
        checks++; if (de != 82) begin errors++; $display("FAIL t2_done_edge got %0d exp 82", de); end
        checks++; if (bus.img_data[17] !== 8'd33) begin errors++; $display("FAIL t2_img17 got %0d exp 33", bus.img_data[17]); end
        checks++; if (bus.img_data[255] !== 8'd239) begin errors++; $display("FAIL t2_img255 got %0d exp 239", bus.img_data[255]); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL t2_err got %b exp 0", bus.err); end
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (bus.img_data[i] !== exp_img(0, 8, i)) begin
                errors++; $display("FAIL t2_img[%0d] got %0d exp %0d", i, bus.img_data[i], exp_img(0, 8, i));
            end
        end
    endtask

    task automatic test_oob();
        int de, dc, bc, fb, pb;
        bus.filt_base = 7'd0; bus.img_base = 7'd100; bus.line_stride = 8'd4;
        run_pass(1'b0, 1'b0, de, dc, bc, fb, pb);
        checks++; if (de != 82) begin errors++; $display("FAIL t3_done_edge got %0d exp 82", de); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL t3_err got %b exp 1", bus.err); end
        checks++; if (bus.img_data[111] !== 8'd255) begin errors++; $display("FAIL t3_img111 got %0d exp 255", bus.img_data[111]); end
        checks++; if (bus.img_data[112] !== 8'd0) begin errors++; $display("FAIL t3_img112 got %0d exp 0", bus.img_data[112]); end
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (bus.img_data[i] !== exp_img(100, 4, i)) begin
                errors++; $display("FAIL t3_img[%0d] got %0d exp %0d", i, bus.img_data[i], exp_img(100, 4, i));
            end
        end
        repeat (5) @(negedge clk);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL t3_err_sticky got %b exp 1", bus.err); end
    endtask

    task automatic test_busy_ignore();
        int de, dc, bc, fb, pb;
        bus.filt_base = 7'd0; bus.img_base = 7'd16; bus.line_stride = 8'd4;
        run_pass(1'b0, 1'b1, de, dc, bc, fb, pb);
        checks++; if (de != 82) begin errors++; $display("FAIL t4_done_edge got %0d exp 82", de); end
        checks++; if (dc != 1) begin errors++; $display("FAIL t4_done_cnt got %0d exp 1", dc); end
        checks++; if (pb != 0) begin errors++; $display("FAIL t4_post_busy got %0d exp 0", pb); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL t4_err_cleared got %b exp 0", bus.err); end
        checks++; if (bus.filters[1][4] !== 8'd20) begin errors++; $display("FAIL t4_filt14 got %0d exp 20", bus.filters[1][4]); end
        checks++; if (bus.filters[0][0] !== 8'd0) begin errors++; $display("FAIL t4_filt00 got %0d exp 0", bus.filters[0][0]); end
        checks++; if (bus.img_data[16] !== 8'd80) begin errors++; $display("FAIL t4_img16 got %0d exp 80", bus.img_data[16]); end
    endtask

    task automatic test_abort();
        int de, dc, bc, fb, pb;
        int dn;
        logic bz;
        dn = 0;
        bz = 1'b0;
        bus.filt_base = 7'd0; bus.img_base = 7'd16; bus.line_stride = 8'd4;
        @(negedge clk);
        bus.start = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 0) bus.start = 1'b0;
            if (bus.done) dn++;
            bz = bus.busy;
        end
        checks++; if (bz !== 1'b1) begin errors++; $display("FAIL t5_busy_before got %b exp 1", bz); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t5_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0 || dn != 0) begin errors++; $display("FAIL t5_done got %b/%0d exp 0/0", bus.done, dn); end
        checks++; if (bus.img_data !== '0) begin errors++; $display("FAIL t5_img got nonzero exp 0"); end
        checks++; if (bus.filters !== '0) begin errors++; $display("FAIL t5_filt got nonzero exp 0"); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_pass(1'b0, 1'b0, de, dc, bc, fb, pb);
        checks++; if (de != 82) begin errors++; $display("FAIL t5_done_edge got %0d exp 82", de); end
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (bus.img_data[i] !== exp_img(16, 4, i)) begin
                errors++; $display("FAIL t5_img[%0d] got %0d exp %0d", i, bus.img_data[i], exp_img(16, 4, i));
            end
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (bus.filters[i/16][i%16] !== exp_elem(i / 4, i % 4)) begin
                errors++; $display("FAIL t5_filt[%0d] got %0d exp %0d", i, bus.filters[i/16][i%16], exp_elem(i / 4, i % 4));
            end
        end
    endtask

    task automatic test_load_start();
        int de, dc, bc, fb, pb;
        bus.filt_base = 7'd0; bus.img_base = 7'd16; bus.line_stride = 8'd4;
        bus.load_addr = 7'd0;
        bus.load_data = 32'hA1B2C3D4;
        run_pass(1'b1, 1'b0, de, dc, bc, fb, pb);
        checks++; if (de != 82) begin errors++; $display("FAIL t6_done_edge got %0d exp 82", de); end
        checks++; if (bus.filters[0][0] !== 8'hD4) begin errors++; $display("FAIL t6_filt00 got %0h exp d4", bus.filters[0][0]); end
        checks++; if (bus.filters[0][1] !== 8'hC3) begin errors++; $display("FAIL t6_filt01 got %0h exp c3", bus.filters[0][1]); end
        checks++; if (bus.filters[0][2] !== 8'hB2) begin errors++; $display("FAIL t6_filt02 got %0h exp b2", bus.filters[0][2]); end
        checks++; if (bus.filters[0][3] !== 8'hA1) begin errors++; $display("FAIL t6_filt03 got %0h exp a1", bus.filters[0][3]); end
        checks++; if (bus.filters[0][4] !== 8'd4) begin errors++; $display("FAIL t6_filt04 got %0d exp 4", bus.filters[0][4]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_stride();
        test_oob();
        test_busy_ignore();
        test_abort();
        test_load_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
